// File: rtl/pid_ctrl_mc.sv
// pid_ctrl_mc: time-multiplexed multi-channel fixed-point PID with clamped integrator, anti-windup and output saturation
// Define PID_DERIV_FILTER_EN to add a per-channel IIR filter on the derivative term.
module pid_ctrl_mc #(
    parameter int W = 19,
    parameter int FRAC = 15,
    parameter int NCH = 4,
    parameter int INT_LIM = 2**(W-1)-1,
    parameter int OUT_MAX = 2**(W-1)-1,
    parameter int OUT_MIN = -(2**(W-1)),
`ifdef PID_DERIV_FILTER_EN
    parameter int ALPHA_SH = 2,
`endif
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH_W-1:0] in_ch,
    input  logic [W-1:0]    in_ref,
    input  logic [W-1:0]    in_meas,
    input  logic            cfg_we,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [1:0]      cfg_sel,
    input  logic [W-1:0]    cfg_data,
    input  logic            ch_clr,
    input  logic [CH_W-1:0] clr_ch,
    output logic            out_valid,
    output logic [CH_W-1:0] out_ch,
    output logic [W-1:0]    out_u,
    output logic            out_sat
);
    localparam int PW = 2*W-FRAC;
    localparam int SW = PW+2;
    localparam logic signed [2*W-1:0] RND = (2*W)'(2**(FRAC-1));

    typedef enum logic [2:0] {IDLE, ERR, MUL, SUM, OUT} state_t;
    state_t state, state_nx;

    logic [CH_W-1:0] ch;
    logic signed [W-1:0] ref_r, meas_r, e, d, int_new;
    logic signed [W-1:0] kp [NCH];
    logic signed [W-1:0] ki [NCH];
    logic signed [W-1:0] kd [NCH];
    logic signed [W-1:0] integ [NCH];
    logic signed [W-1:0] e_prev [NCH];
`ifdef PID_DERIV_FILTER_EN
    logic signed [W-1:0] df [NCH];
    logic signed [W:0] fd, fs;
`endif
    logic signed [PW-1:0] p, i_t, dd;
    logic signed [W-1:0] e_c, d_c, dk_c, int_c;
    logic signed [PW:0] int_sum;
    logic signed [SW-1:0] u_c;
    logic sat_hi, sat_lo, hi, lo, ch_ok, hold;

    function automatic logic signed [W-1:0] sat_w(input logic signed [W:0] x);
        return (x[W] != x[W-1]) ? {x[W], {(W-1){~x[W]}}} : x[W-1:0];
    endfunction

    function automatic logic signed [PW-1:0] scale(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        logic signed [2*W-1:0] x;
        x = (2*W)'(a) * (2*W)'(b) + RND;
        return PW'(x >>> FRAC);
    endfunction

    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = (state == IDLE) ? (in_valid ? ERR : IDLE) :
                   (state == ERR)  ? MUL :
                   (state == MUL)  ? SUM :
                   (state == SUM)  ? OUT : IDLE;
    end

    always_comb begin
        in_ready = state == IDLE;
        out_valid = state == OUT;
    end

    assign out_ch = ch;

    always_comb begin
        ch_ok = 32'(ch) < NCH;
        e_c = sat_w({ref_r[W-1], ref_r} - {meas_r[W-1], meas_r});
        d_c = sat_w({e_c[W-1], e_c} - {e_prev[ch][W-1], e_prev[ch]});
`ifdef PID_DERIV_FILTER_EN
        fd = {d_c[W-1], d_c} - {df[ch][W-1], df[ch]};
        fs = {df[ch][W-1], df[ch]} + (fd >>> ALPHA_SH);
        dk_c = fs[W-1:0];
`else
        dk_c = d_c;
`endif
        int_sum = (PW+1)'(integ[ch]) + (PW+1)'(i_t);
        int_c = (int_sum > (PW+1)'(INT_LIM)) ? W'(INT_LIM) :
                (int_sum < (PW+1)'(-INT_LIM)) ? W'(-INT_LIM) : int_sum[W-1:0];
        u_c = SW'(p) + SW'(int_c) + SW'(dd);
        hi = u_c > SW'(OUT_MAX);
        lo = u_c < SW'(OUT_MIN);
        // integrator is frozen only when it would push further into the clipped side
        hold = (sat_hi & ~i_t[PW-1] & (|i_t)) | (sat_lo & i_t[PW-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch <= '0;
            ref_r <= '0;
            meas_r <= '0;
            e <= '0;
            d <= '0;
            p <= '0;
            i_t <= '0;
            dd <= '0;
            int_new <= '0;
            sat_hi <= 1'b0;
            sat_lo <= 1'b0;
            out_u <= '0;
            out_sat <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                integ[k] <= '0;
                e_prev[k] <= '0;
`ifdef PID_DERIV_FILTER_EN
                df[k] <= '0;
`endif
            end
        end else begin
            if (state == IDLE && in_valid) begin
                ch <= in_ch;
                ref_r <= in_ref;
                meas_r <= in_meas;
            end
            if (state == ERR) begin
                e <= e_c;
                d <= dk_c;
            end
            if (state == MUL) begin
                p <= scale(kp[ch], e);
                i_t <= scale(ki[ch], e);
                dd <= scale(kd[ch], d);
            end
            if (state == SUM) begin
                int_new <= int_c;
                sat_hi <= hi;
                sat_lo <= lo;
                out_u <= ch_ok ? (hi ? W'(OUT_MAX) : lo ? W'(OUT_MIN) : u_c[W-1:0]) : '0;
                out_sat <= ch_ok & (hi | lo);
            end
            if (state == OUT && ch_ok) begin
                if (!hold) integ[ch] <= int_new;
                e_prev[ch] <= e;
`ifdef PID_DERIV_FILTER_EN
                df[ch] <= d;
`endif
            end
            // placed last so a clear overrides a same-cycle commit
            if (ch_clr && 32'(clr_ch) < NCH) begin
                integ[clr_ch] <= '0;
                e_prev[clr_ch] <= '0;
`ifdef PID_DERIV_FILTER_EN
                df[clr_ch] <= '0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                kp[k] <= '0;
                ki[k] <= '0;
                kd[k] <= '0;
            end
        end else if (cfg_we && 32'(cfg_ch) < NCH) begin
            if (cfg_sel == 2'd0) kp[cfg_ch] <= cfg_data;
            if (cfg_sel == 2'd1) ki[cfg_ch] <= cfg_data;
            if (cfg_sel == 2'd2) kd[cfg_ch] <= cfg_data;
        end
    end
endmodule

// File: tb/tb_pid_ctrl_mc.sv
// tb_pid_ctrl_mc: scoreboard bench for pid_ctrl_mc against an arithmetic PID reference model
module tb_pid_ctrl_mc;
    localparam int W = 19;
    localparam int NCH = 4;
    localparam int CH_W = 2;
    localparam longint MAXV = 262143;
    localparam longint MINV = -262144;
    localparam longint LIM = 262143;

    logic clk = 0, rst = 1, in_valid = 0, cfg_we = 0, ch_clr = 0;
    logic in_ready, out_valid, out_sat;
    logic [CH_W-1:0] in_ch = 0, cfg_ch = 0, clr_ch = 0, out_ch;
    logic [1:0] cfg_sel = 0;
    logic [W-1:0] in_ref = 0, in_meas = 0, cfg_data = 0, out_u;

    int total = 0, bad = 0, nvalid = 0, nv0 = 0;
    longint cyc = 0, last_acc = 0, acc_a = 0;

    typedef struct {int ch; longint u; bit sat; longint acc;} exp_t;
    exp_t sb[$];
    exp_t mx;
    longint kp[NCH], ki[NCH], kd[NCH], integ[NCH], ep[NCH];

    pid_ctrl_mc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .in_ref(in_ref), .in_meas(in_meas), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
        .cfg_data(cfg_data), .ch_clr(ch_clr), .clr_ch(clr_ch), .out_valid(out_valid),
        .out_ch(out_ch), .out_u(out_u), .out_sat(out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint clampl(input longint x, input longint lo, input longint hi);
        return x < lo ? lo : x > hi ? hi : x;
    endfunction

    // gain * value in Q.15, rounded half up to an integer
    function automatic longint rs(input longint k, input longint x);
        return (k * x + 16384) >>> 15;
    endfunction

    task automatic reset_model();
        for (int c = 0; c < NCH; c++) begin
            kp[c] = 0; ki[c] = 0; kd[c] = 0; integ[c] = 0; ep[c] = 0;
        end
        sb.delete();
    endtask

    task automatic model(input int c, input longint r, input longint m);
        longint e, dv, p, i, dd, ni, u, uo;
        exp_t x;
        e = clampl(r - m, MINV, MAXV);
        dv = clampl(e - ep[c], MINV, MAXV);
        p = rs(kp[c], e);
        i = rs(ki[c], e);
        dd = rs(kd[c], dv);
        ni = clampl(integ[c] + i, -LIM, LIM);
        u = p + ni + dd;
        uo = clampl(u, MINV, MAXV);
        if (!((u > MAXV && i > 0) || (u < MINV && i < 0))) integ[c] = ni;
        ep[c] = e;
        x.ch = c; x.u = uo; x.sat = (uo != u); x.acc = cyc;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            nvalid++;
            if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
            else begin
                mx = sb.pop_front();
                chk("out_ch", out_ch, mx.ch);
                chk("out_u", $signed(out_u), mx.u);
                chk("out_sat", out_sat, mx.sat);
                chk("latency", cyc - mx.acc, 4);
            end
        end
    end

    task automatic send(input int c, input int r, input int m);
        int n = 0;
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        in_valid = 1; in_ch = c[CH_W-1:0]; in_ref = r[W-1:0]; in_meas = m[W-1:0];
        last_acc = cyc;
        model(c, r, m);
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic set_cfg(input int c, input int sel, input int v);
        cfg_we = 1; cfg_ch = c[CH_W-1:0]; cfg_sel = sel[1:0]; cfg_data = v[W-1:0];
        if (sel == 0) kp[c] = v;
        else if (sel == 1) ki[c] = v;
        else if (sel == 2) kd[c] = v;
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic clr(input int c);
        ch_clr = 1; clr_ch = c[CH_W-1:0];
        integ[c] = 0; ep[c] = 0;
        @(negedge clk);
        ch_clr = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 40) begin @(negedge clk); n++; end
        if (sb.size() != 0 || !in_ready) chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_model();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_u", out_u, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 0;
        @(negedge clk);

        set_cfg(0, 0, 32768);
        send(0, 1000, 0);
        drain();

        set_cfg(1, 1, 16384);
        repeat (3) begin send(1, 100, 0); drain(); end
        clr(1);
        send(1, 100, 0);
        drain();

        set_cfg(2, 2, 32768);
        send(2, 0, 0); drain();
        send(2, 200, 0); drain();
        send(2, 200, 0); drain();

        set_cfg(3, 0, 32768);
        send(3, 200000, -200000); drain();
        send(3, -200000, 200000); drain();

        set_cfg(0, 0, 0);
        set_cfg(0, 1, 32768);
        clr(0);
        repeat (4) begin send(0, 262143, 0); drain(); end
        send(0, -1000, 0); drain();
        set_cfg(0, 0, 32768);
        clr(0);
        repeat (3) begin send(0, 262143, 0); drain(); end
        send(0, -1000, 0); drain();

        send(0, 500, 0);
        chk("busy_in_ready", in_ready, 0);
        acc_a = last_acc;
        send(1, 300, 0);
        chk("throughput", last_acc - acc_a, 5);
        drain();

        set_cfg(0, 0, 16384); set_cfg(0, 1, 0);
        set_cfg(1, 0, 0); set_cfg(1, 1, 16384); set_cfg(1, 2, 0);
        clr(0); clr(1);
        send(0, 4000, 0);
        @(negedge clk);
        set_cfg(0, 0, 32768);
        drain();
        send(1, 100, 0);
        repeat (3) @(negedge clk);
        clr(1);
        drain();
        send(0, 4000, 0); drain();
        send(1, 100, 0); drain();

        send(0, 1000, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        reset_model();
        nv0 = nvalid;
        @(negedge clk);
        rst = 0;
        chk("rst_mid_out_u", out_u, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        repeat (8) @(negedge clk);
        chk("no_valid_after_rst", nvalid - nv0, 0);
        send(0, 1000, 0); drain();

        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < 3; s++) set_cfg(c, s, int'($urandom_range(0, 131072)) - 65536);
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0)
                set_cfg($urandom_range(0, 3), $urandom_range(0, 3), int'($urandom_range(0, 131072)) - 65536);
            if ($urandom_range(0, 9) == 0) clr($urandom_range(0, 3));
            send($urandom_range(0, 3), int'($urandom_range(0, 524287)) - 262144,
                 int'($urandom_range(0, 524287)) - 262144);
            drain();
        end
        for (int k = 0; k < 20; k++)
            send($urandom_range(0, 3), int'($urandom_range(0, 524287)) - 262144,
                 int'($urandom_range(0, 524287)) - 262144);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
